pad_out_pacer: RTL and testbench

PAD_OUT_PACER -- requirements
Module: pad_out_pacer

---
 rtl/pad_out_pkg.sv | 12 +
 rtl/pad_out_fifo.sv | 59 +++++
 rtl/pad_out_pacer.sv | 89 ++++++++
 tb/tb_pad_out_pacer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pad_out_pkg.sv
// Shared types and constants for the pad output pacer.
// The pacer FSM state and the hold-counter width live here so FIFO, pacer and bench agree.
package pad_out_pkg;

  localparam int hold_w = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_t;

endpackage

// File: rtl/pad_out_fifo.sv
// Word FIFO in front of the pad pacer: power-of-two depth, wrapping pointers plus a
// 0..depth occupancy count. Push is ignored when full, pop is ignored when empty.
module pad_out_fifo #(
  parameter int width = 8,
  parameter int depth = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [width-1:0]         wdata,
  input  logic                     pop,
  output logic [width-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(depth):0]   count
);

  localparam int aw = $clog2(depth);

  logic [width-1:0] mem [depth];
  logic [aw-1:0]    wr_ptr;
  logic [aw-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (aw+1)'(depth));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage carries no reset; pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + aw'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + aw'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (aw+1)'(1);
        2'b01:   count <= count - (aw+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pad_out_pacer.sv
// Paces buffered words onto a registered pad bus, holding each word for i_hold+1 clocks
// and pulsing o_strobe in the first cycle of every new word.
module pad_out_pacer
  import pad_out_pkg::*;
#(
  parameter int               width      = 8,
  parameter int               depth      = 4,
  parameter logic [width-1:0] idle_value = '0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  input  logic [width-1:0]   i_data,
  output logic               o_ready,
  input  logic [7:0]         i_hold,
  output logic [width-1:0]   o_pad,
  output logic               o_strobe,
  output logic               o_busy,
  output logic               o_empty
);

  // Handshake: a word transfers on a rising edge where i_valid && o_ready; o_ready is
  // simply !full and never depends on i_valid or on a same-cycle pop.

  logic [width-1:0]        head;
  logic                    full;
  logic                    fifo_empty;
  logic [$clog2(depth):0]  count;
  logic                    have_word;
  logic                    load;
  state_t                  state;
  logic [hold_w-1:0]       cnt;

  pad_out_fifo #(
    .width (width),
    .depth (depth)
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (i_valid),
    .wdata (i_data),
    .pop   (load),
    .rdata (head),
    .full  (full),
    .empty (fifo_empty),
    .count (count)
  );

  // Only the registered count gates a load, so a word pushed this edge waits one clock.
  assign have_word = (count != '0);
  assign load      = have_word && ((state == IDLE) || (cnt == '0));

  assign o_ready = !full;
  assign o_empty = fifo_empty;
  assign o_busy  = (state == DRIVE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      cnt      <= '0;
      o_pad    <= idle_value;
      o_strobe <= 1'b0;
    end else begin
      o_strobe <= 1'b0;
      unique case (state)
        IDLE: begin
          if (have_word) begin
            o_pad    <= head;
            cnt      <= i_hold;
            o_strobe <= 1'b1;
            state    <= DRIVE;
          end
        end
        DRIVE: begin
          if (cnt != '0) begin
            cnt <= cnt - hold_w'(1);
          end else if (have_word) begin
            o_pad    <= head;
            cnt      <= i_hold;
            o_strobe <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pad_out_pacer.sv
// Bench for pad_out_pacer: directed scenarios plus a randomized run, all checked against
// a word-queue model that tracks how many cycles the current pad word still has to show.
module tb_pad_out_pacer;

  localparam int               width      = 8;
  localparam int               depth      = 4;
  localparam logic [width-1:0] idle_value = 8'h5A;

  logic               clk;
  logic               rst;
  logic               valid;
  logic [width-1:0]   data;
  logic               ready;
  logic [7:0]         hold;
  logic [width-1:0]   pad;
  logic               strobe;
  logic               busy;
  logic               empty;

  int n_checks;
  int n_fail;

  // Reference model: exp_q holds accepted words not yet shown, m_rem is the number of
  // cycles the word on the pad still has to be shown (0 when nothing is being shown).
  logic [width-1:0] exp_q[$];
  logic [width-1:0] m_pad;
  logic             m_strobe;
  int               m_rem;
  logic             m_acc;

  pad_out_pacer #(
    .width      (width),
    .depth      (depth),
    .idle_value (idle_value)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_valid  (valid),
    .i_data   (data),
    .o_ready  (ready),
    .i_hold   (hold),
    .o_pad    (pad),
    .o_strobe (strobe),
    .o_busy   (busy),
    .o_empty  (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge: advance the model with the inputs the DUT saw, then settle.
  task automatic tick();
    int n;
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      m_pad    = idle_value;
      m_strobe = 1'b0;
      m_rem    = 0;
      m_acc    = 1'b0;
    end else begin
      n        = exp_q.size();
      m_acc    = valid && (n < depth);
      m_strobe = 1'b0;
      if (m_rem > 1) begin
        m_rem = m_rem - 1;
      end else if (n > 0) begin
        m_pad    = exp_q.pop_front();
        m_rem    = int'(hold) + 1;
        m_strobe = 1'b1;
      end else begin
        m_rem = 0;
      end
      if (m_acc) exp_q.push_back(data);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 1'b1; data = 8'hEE; hold = 8'd0;
    tick();
    tick();
    rst = 1'b0; valid = 1'b0;
    n_checks++;
    if ({pad, strobe, busy, empty, ready} !== {idle_value, 1'b0, 1'b0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL reset: pad/strobe/busy/empty/ready got %h %b %b %b %b want %h 0 0 1 1",
               pad, strobe, busy, empty, ready, idle_value);
    end
  endtask

  task automatic test_single_word();
    logic [4:0] exp_seq [5];
    hold = 8'd2; valid = 1'b1; data = 8'h11;
    tick();
    valid = 1'b0;
    n_checks++;
    if (pad !== idle_value || empty !== 1'b0) begin
      n_fail++;
      $display("FAIL single_push_edge: pad %h empty %b want %h 0", pad, empty, idle_value);
    end
    // strobe,busy per cycle after edges k+1..k+5; pad must read 8'h11 throughout
    exp_seq[0] = 5'b11; exp_seq[1] = 5'b01; exp_seq[2] = 5'b01;
    exp_seq[3] = 5'b00; exp_seq[4] = 5'b00;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (pad !== 8'h11 || {strobe, busy} !== exp_seq[i][1:0]) begin
        n_fail++;
        $display("FAIL single_cycle%0d: pad %h strobe %b busy %b want 11 %b %b",
                 i, pad, strobe, busy, exp_seq[i][1], exp_seq[i][0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [width-1:0] w [4];
    for (int i = 0; i < 4; i++) w[i] = width'($urandom_range(0, 255));
    hold = 8'd0;
    for (int i = 0; i < 6; i++) begin
      valid = (i < 4);
      data  = (i < 4) ? w[i] : '0;
      tick();
      n_checks++;
      if (ready !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_ready%0d: ready %b want 1", i, ready);
      end
      if (i >= 1 && i <= 4) begin
        n_checks++;
        if (pad !== w[i-1] || strobe !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_word%0d: pad %h strobe %b want %h 1", i-1, pad, strobe, w[i-1]);
        end
      end
    end
    valid = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || strobe !== 1'b0 || pad !== w[3]) begin
      n_fail++;
      $display("FAIL b2b_idle: busy %b strobe %b pad %h want 0 0 %h", busy, strobe, pad, w[3]);
    end
  endtask

  task automatic test_fill_to_full();
    logic [width-1:0] w [6];
    logic [width-1:0] got[$];
    int idx;
    logic saw_low;
    for (int i = 0; i < 6; i++) w[i] = width'(8'hA0 + i);
    hold = 8'd7; idx = 0; saw_low = 1'b0;
    valid = 1'b1; data = w[0];
    for (int c = 0; c < 200 && (got.size() < 6 || busy); c++) begin
      tick();
      n_checks++;
      if ({pad, strobe, busy, empty, ready} !==
          {m_pad, m_strobe, (m_rem > 0), (exp_q.size() == 0), (exp_q.size() < depth)}) begin
        n_fail++;
        $display("FAIL full_model c%0d: pad %h s%b b%b e%b r%b want %h s%b b%b e%b r%b",
                 c, pad, strobe, busy, empty, ready, m_pad, m_strobe, (m_rem > 0),
                 (exp_q.size() == 0), (exp_q.size() < depth));
      end
      if (m_acc) idx++;
      valid = (idx < 6);
      data  = (idx < 6) ? w[idx] : '0;
      if (ready === 1'b0) saw_low = 1'b1;
      if (strobe === 1'b1) got.push_back(pad);
    end
    valid = 1'b0;
    n_checks++;
    if (saw_low !== 1'b1) begin
      n_fail++;
      $display("FAIL full_ready_drop: ready never went low, want a low cycle");
    end
    n_checks++;
    if (got.size() != 6) begin
      n_fail++;
      $display("FAIL full_count: %0d words shown want 6", got.size());
    end
    for (int i = 0; i < got.size() && i < 6; i++) begin
      n_checks++;
      if (got[i] !== w[i]) begin
        n_fail++;
        $display("FAIL full_order%0d: got %h want %h", i, got[i], w[i]);
      end
    end
  endtask

  task automatic test_hold_change();
    int n;
    hold = 8'd3; valid = 1'b1; data = 8'h3C;
    tick();
    data = 8'hC3;
    tick();
    valid = 1'b0; hold = 8'd0;
    n_checks++;
    if (pad !== 8'h3C || strobe !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_first: pad %h strobe %b want 3c 1", pad, strobe);
    end
    n = 1;
    for (int c = 0; c < 20 && strobe !== 1'b1 || c == 0; c++) begin
      tick();
      if (strobe !== 1'b1) n++;
    end
    n_checks++;
    if (n != 4 || pad !== 8'hC3) begin
      n_fail++;
      $display("FAIL hold_len_first: %0d cycles next pad %h want 4 c3", n, pad);
    end
    tick();
    n_checks++;
    if (busy !== 1'b0 || strobe !== 1'b0 || pad !== 8'hC3) begin
      n_fail++;
      $display("FAIL hold_len_second: busy %b strobe %b pad %h want 0 0 c3", busy, strobe, pad);
    end
  endtask

  task automatic test_reset_mid();
    int strobes;
    hold = 8'd5;
    for (int i = 0; i < 4; i++) begin
      valid = 1'b1; data = width'(8'h70 + i);
      tick();
    end
    valid = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || exp_q.size() != 3) begin
      n_fail++;
      $display("FAIL rstmid_setup: busy %b queued %0d want 1 3", busy, exp_q.size());
    end
    rst = 1'b1; valid = 1'b1; data = 8'hFF;
    tick();
    rst = 1'b0; valid = 1'b0;
    n_checks++;
    if ({pad, strobe, busy, empty, ready} !== {idle_value, 1'b0, 1'b0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL rstmid_state: pad %h s%b b%b e%b r%b want %h 0 0 1 1",
               pad, strobe, busy, empty, ready, idle_value);
    end
    strobes = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (strobe === 1'b1) strobes++;
    end
    n_checks++;
    if (strobes != 0 || pad !== idle_value) begin
      n_fail++;
      $display("FAIL rstmid_quiet: %0d strobes pad %h want 0 %h", strobes, pad, idle_value);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst   = ($urandom_range(0, 99) == 0);
      valid = ($urandom_range(0, 3) != 0);
      data  = width'($urandom_range(0, 255));
      hold  = 8'($urandom_range(0, 3));
      tick();
      n_checks++;
      if ({pad, strobe, busy, empty, ready} !==
          {m_pad, m_strobe, (m_rem > 0), (exp_q.size() == 0), (exp_q.size() < depth)}) begin
        n_fail++;
        $display("FAIL random c%0d: pad %h s%b b%b e%b r%b want %h s%b b%b e%b r%b",
                 c, pad, strobe, busy, empty, ready, m_pad, m_strobe, (m_rem > 0),
                 (exp_q.size() == 0), (exp_q.size() < depth));
      end
    end
    rst = 1'b0; valid = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b1; valid = 1'b0; data = '0; hold = '0;
    m_pad = idle_value; m_strobe = 1'b0; m_rem = 0; m_acc = 1'b0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_fill_to_full();
    test_hold_change();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
